// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, legal-op bound and requester IDs.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;

  // Highest legal op code; anything above it is flagged as an error.
  localparam logic [3:0] OP_MAX = 4'd8;

  // Requester identifiers carried on the response channel.
  localparam logic ID_EXE = 1'b0;
  localparam logic ID_AUX = 1'b1;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational integer ALU. Illegal op codes produce 0.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic signed [XLEN-1:0] sra_s;
  logic [SH_W-1:0]        shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SH_W-1:0];
  assign sra_s = a_s >>> shamt;

  // Decode the op and compute the result.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = sra_s;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0)
// and the auxiliary address/CSR unit (port 1). The ALU result is held in a
// single output register and returned tagged with the owning requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  logic            last_grant;
  logic            can_accept;
  logic            grant0;
  logic            grant1;
  logic            grant_any;
  logic            sel_id;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [3:0]      sel_op;
  logic [XLEN-1:0] alu_result;

  // The output register can take a new entry when empty or draining now.
  assign can_accept = !rsp_valid || rsp_ready;

  // Round-robin grant: a contended cycle goes to the port not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        grant0 = (last_grant == ID_AUX);
        grant1 = (last_grant == ID_EXE);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign grant_any  = grant0 || grant1;
  assign sel_id     = grant1 ? ID_AUX : ID_EXE;

  // Steer the granted requester's operands into the ALU.
  always_comb begin
    sel_a  = req0_a;
    sel_b  = req0_b;
    sel_op = req0_op;
    if (grant1) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end
  end

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op    (sel_op),
    .a     (sel_a),
    .b     (sel_b),
    .result(alu_result)
  );

  // ---- grant edge: ALU result captured into the response register ----
  // Response register, arbitration history and grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= ID_EXE;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      last_grant <= ID_AUX;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant_any) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= sel_id;
        rsp_result <= alu_result;
        rsp_err    <= (sel_op > OP_MAX);
        last_grant <= sel_id;
      end else if (rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
      if (grant0) grant_cnt0 <= sat_inc(grant_cnt0);
      if (grant1) grant_cnt1 <= sat_inc(grant_cnt1);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenario tasks plus a
// scoreboard that predicts every response from the accepted requests.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [15:0] grant_cnt0, grant_cnt1;

  // Second instance with 2-bit counters for the saturation scenario.
  logic        sat_req0_ready, sat_req1_ready, sat_rsp_valid, sat_rsp_id, sat_rsp_err;
  logic [31:0] sat_rsp_result;
  logic [1:0]  sat_grant_cnt0, sat_grant_cnt1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [32:0] mon_m;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  alu_arbiter #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(sat_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(sat_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(sat_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(sat_rsp_id),
    .rsp_result(sat_rsp_result), .rsp_err(sat_rsp_err),
    .grant_cnt0(sat_grant_cnt0), .grant_cnt1(sat_grant_cnt1)
  );

  // Reference ALU: returns {err, result}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] as_, bs_, sr;
    as_ = a;
    bs_ = b;
    sr  = as_ >>> b[4:0];
    r   = 32'd0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (as_ < bs_) ? 32'd1 : 32'd0;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = sr;
      default: r = 32'd0;
    endcase
    return {(op > 4'd8), r};
  endfunction

  // Scoreboard: pop on response consumption, push on each request handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got id=%0d res=%h err=%0d, required no response",
                   rsp_id, rsp_result, rsp_err);
        end else begin
          mon_e = sb.pop_front();
          if ({rsp_id, rsp_err, rsp_result} !== {mon_e.id, mon_e.err, mon_e.res}) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d err=%0d res=%h, required id=%0d err=%0d res=%h",
                     rsp_id, rsp_err, rsp_result, mon_e.id, mon_e.err, mon_e.res);
          end
        end
      end
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL one_ready: got both readys high, required at most one");
      end
      if (req0_valid && req0_ready) begin
        mon_m = model(req0_op, req0_a, req0_b);
        sb.push_back({1'b0, mon_m[32], mon_m[31:0]});
      end
      if (req1_valid && req1_ready) begin
        mon_m = model(req1_op, req1_a, req1_b);
        sb.push_back({1'b1, mon_m[32], mon_m[31:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = 1'b1;
    req0_op    = op;
    req0_a     = a;
    req0_b     = b;
    step();
    req0_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got valid/id/err=%b, required 000", {rsp_valid, rsp_id, rsp_err});
    end
    checks++;
    if (rsp_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_result: got %h, required 0", rsp_result);
    end
    checks++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d, required 0/0", grant_cnt0, grant_cnt1);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_op    = 4'd0;
    req0_a     = 32'd5;
    req0_b     = 32'd7;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got r0/r1=%b, required 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b100 || rsp_result !== 32'd12) begin
      errors++;
      $display("FAIL single_rsp: got v/id/err=%b res=%0d, required 100 res=12",
               {rsp_valid, rsp_id, rsp_err}, rsp_result);
    end
    checks++;
    if (grant_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL single_cnt0: got %0d, required 1", grant_cnt0);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd10; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 4'd6; req1_a = 32'd1;  req1_b = 32'd4;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL contend_first: got r0/r1=%b, required 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if (rsp_id !== 1'b0 || rsp_result !== 32'd7) begin
      errors++;
      $display("FAIL contend_rsp0: got id=%0d res=%0d, required id=0 res=7", rsp_id, rsp_result);
    end
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL contend_second: got req1_ready=%b, required 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    checks++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'd16) begin
      errors++;
      $display("FAIL contend_rsp1: got id=%0d res=%0d, required id=1 res=16", rsp_id, rsp_result);
    end
    step();
  endtask

  task automatic test_fairness();
    do_reset();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'd3; req1_b = 32'd4;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got r0/r1=%b, required %b", i,
                 {req0_ready, req1_ready}, ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (grant_cnt0 !== 16'd4 || grant_cnt1 !== 16'd4) begin
      errors++;
      $display("FAIL fair_cnt: got %0d/%0d, required 4/4", grant_cnt0, grant_cnt1);
    end
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    send0(4'd0, 32'd1, 32'd2);
    rsp_ready  = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd6; req1_b = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00 || rsp_valid !== 1'b1 ||
          rsp_result !== 32'd3 || rsp_id !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got r=%b v=%b id=%0d res=%0d, required r=00 v=1 id=0 res=3",
                 i, {req0_ready, req1_ready}, rsp_valid, rsp_id, rsp_result);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got req1_ready=%b, required 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    checks++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'd5) begin
      errors++;
      $display("FAIL bp_next: got id=%0d res=%0d, required id=1 res=5", rsp_id, rsp_result);
    end
    step();
  endtask

  task automatic test_illegal_signed();
    rsp_ready = 1'b1;
    send0(4'b1111, 32'd123, 32'd456);
    checks++;
    if (rsp_result !== 32'd0 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: got res=%h err=%b, required res=0 err=1", rsp_result, rsp_err);
    end
    send0(4'd5, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (rsp_result !== 32'd1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL slt_signed: got res=%h err=%b, required res=1 err=0", rsp_result, rsp_err);
    end
    send0(4'd8, 32'h8000_0000, 32'd4);
    checks++;
    if (rsp_result !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra: got %h, required f8000000", rsp_result);
    end
    send0(4'd8, 32'h0000_0001, 32'd0);
    checks++;
    if (rsp_result !== 32'd1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL op_max_legal: got res=%h err=%b, required res=1 err=0", rsp_result, rsp_err);
    end
    step();
  endtask

  task automatic test_reset_sat();
    rsp_ready = 1'b0;
    send0(4'd0, 32'd2, 32'd2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || grant_cnt0 !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b cnt0=%0d, required v=0 cnt0=0", rsp_valid, grant_cnt0);
    end
    rsp_ready  = 1'b1;
    req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd7; req1_b = 32'd8;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    req1_valid = 1'b0;
    checks++;
    if (grant_cnt1 !== 16'd5 || rsp_result !== 32'd15) begin
      errors++;
      $display("FAIL regrant: got cnt1=%0d res=%0d, required cnt1=5 res=15", grant_cnt1, rsp_result);
    end
    checks++;
    if (sat_grant_cnt1 !== 2'd3) begin
      errors++;
      $display("FAIL saturate: got %0d, required 3", sat_grant_cnt1);
    end
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(posedge clk);
    #2;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_illegal_signed();
    test_reset_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle integer ALU between two requesters: port 0 is the execute stage and port 1 is the auxiliary address/CSR unit.
- Each port uses a valid/ready request handshake. Grants are round-robin.
- The ALU result is registered and returned on one shared response channel, tagged with the requester ID.
- Sits between the decode/execute control and the existing alu sub-module.

Parameters:
- XLEN, 32, operand/result width (must match alu).
- CNT_W, 16, width of the per-port saturating grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 granted this cycle.
- req0_a  in  XLEN  port 0 operand a.
- req0_b  in  XLEN  port 0 operand b.
- req0_op  in  4  port 0 alu_op code.
- req1_valid  in  1  port 1 request valid.
- req1_ready  out  1  port 1 granted this cycle.
- req1_a  in  XLEN  port 1 operand a.
- req1_b  in  XLEN  port 1 operand b.
- req1_op  in  4  port 1 alu_op code.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  XLEN  registered ALU result.
- rsp_err  out  1  op code was illegal (>4'b1000); result is 0.
- grant_cnt0  out  CNT_W  saturating count of port 0 grants.
- grant_cnt1  out  CNT_W  saturating count of port 1 grants.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - grant_cnt0/1=0.
  - last_grant=1, so port 0 wins the first contention.
- Ready/grant outputs are combinational, from valid, last_grant and the output register state.
- can_accept = !rsp_valid || rsp_ready. The output register accepts a new entry if it is empty or is being drained this cycle.
- Grant rules, evaluated only when can_accept=1; otherwise both readys are 0:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the port != last_grant.
  - At most one ready is high in any cycle. The handshake completes when reqN_valid && reqN_ready.
- Datapath: a combinational mux selects the granted operands/op into alu. On the grant edge:
  - rsp_result <= alu result.
  - rsp_id <= granted port.
  - rsp_err <= (op > 4'b1000).
  - rsp_valid <= 1.
  - last_grant <= granted port.
- Latency: exactly one cycle from handshake to rsp_valid.
- Throughput: one op per cycle while rsp_ready=1.
- rsp_valid && rsp_ready with no new grant: rsp_valid <= 0 next cycle. rsp_result, rsp_id and rsp_err hold their values (don't-care).
- Backpressure: rsp_valid && !rsp_ready means no grants. Response fields stay stable until accepted.
- Requesters must keep a, b, op stable while valid && !ready. The arbiter does not latch ungranted requests.
- grant_cntN increments on each port-N handshake and saturates at all-ones with no wrap.
- Fairness: with both ports continuously valid and rsp_ready=1, grants strictly alternate 0,1,0,1,…
- Reset mid-operation: a pending response is discarded. A requester held in valid must re-handshake after reset release.

Decomposition:
- Shared package (alu_pkg) holds:
  - ALU op localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_SLT=5, OP_SLL=6, OP_SRL=7, OP_SRA=8.
  - OP_MAX=8, used for the rsp_err check.
  - Requester ID constants: ID_EXE=0, ID_AUX=1.
- One sub-module: the existing alu, instantiated once. Arbitration and the output register stay in alu_arbiter.

Test Plan:
- Single request, no contention:
  - Stimulus: req0 ADD a=5, b=7, rsp_ready=1.
  - Expect: req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_err=0; grant_cnt0=1.
- Contention after reset:
  - Stimulus: req0 SUB 10-3 and req1 SLL 1<<4 both valid.
  - Expect: port 0 granted first (result 7); port 1 granted the next cycle (result 16); rsp_id sequence 0,1.
- Fairness:
  - Stimulus: both ports valid for 8 cycles, rsp_ready=1.
  - Expect: grants alternate, ending with grant_cnt0=4 and grant_cnt1=4; no cycle has both readys high.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles after a response is produced.
  - Expect: readys=0 throughout; rsp_result/rsp_id stable; when rsp_ready=1, the next grant occurs in that same cycle.
- Illegal op and signed cases:
  - Stimulus: op=4'b1111.
  - Expect: rsp_result=0, rsp_err=1.
  - Stimulus: SLT with a=-1, b=1.
  - Expect: result 1.
  - Stimulus: SRA 0x80000000>>>4.
  - Expect: 0xF8000000.
- Reset and saturation:
  - Stimulus: assert rst_n=0 while rsp_valid=1.
  - Expect: rsp_valid=0 immediately (async).
  - Stimulus: force CNT_W=2 and make 5 grants on port 1.
  - Expect: grant_cnt1=3.
